// File: rtl/grad_gen_pipe_pkg.sv
// grad_gen_pipe_pkg: shared constants and arithmetic helpers for the gradient generator
package grad_pkg;
    localparam int ROUND_TRUNC   = 0;
    localparam int ROUND_HALF_UP = 1;

    function automatic int NUM_CH(input int k);
        return k + 2;
    endfunction

    // Offset (in channels) of stage k's channels inside the flattened all-stage bus
    function automatic int ch_base(input int k);
        return k * (k + 3) / 2;
    endfunction

    // Callers pass zero-extended WIDTH-bit values and keep the low WIDTH bits;
    // the 33-bit sum cannot wrap, so the kept result never overflows
    function automatic logic [32:0] conc_avg(input logic [31:0] a, input logic [31:0] b, input logic mode);
        return ({1'b0, a} + {1'b0, b} + 33'(mode)) >> 1;
    endfunction
endpackage

// File: rtl/grad_gen_pipe_if.sv
// grad_gen_pipe_if: inlet/outlet handshake bundle of the gradient generator pipe
interface grad_gen_pipe_if #(
    parameter int WIDTH      = 8,
    parameter int NUM_LAYERS = 3
);
    logic                                in_valid;
    logic                                in_ready;
    logic [WIDTH-1:0]                    soln1_conc;
    logic [WIDTH-1:0]                    soln2_conc;
    logic                                out_valid;
    logic                                out_ready;
    logic [(NUM_LAYERS+2)*WIDTH-1:0]     out_conc;
    logic [$clog2(NUM_LAYERS+1)-1:0]     occupancy;

    modport master (
        output in_valid, soln1_conc, soln2_conc, out_ready,
        input  in_ready, out_valid, out_conc, occupancy
    );

    modport slave (
        input  in_valid, soln1_conc, soln2_conc, out_ready,
        output in_ready, out_valid, out_conc, occupancy
    );
endinterface

// File: rtl/grad_gen_pipe_layer.sv
// grad_layer: one registered mixer layer turning IN_CH channels into IN_CH+1
module grad_layer
    import grad_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int IN_CH      = 2,
    parameter int ROUND_MODE = ROUND_HALF_UP
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid_i,
    input  logic                       take_i,
    input  logic [IN_CH*WIDTH-1:0]     in_data_i,
    output logic                       load_o,
    output logic                       valid_o,
    output logic [(IN_CH+1)*WIDTH-1:0] data_o
);
    logic                       valid_q;
    logic [(IN_CH+1)*WIDTH-1:0] data_q;
    logic [(IN_CH+1)*WIDTH-1:0] data_d;

    for (genvar i = 0; i <= IN_CH; i++) begin : g_ch
        if (i == 0) begin : g_first
            assign data_d[0 +: WIDTH] = in_data_i[0 +: WIDTH];
        end else if (i == IN_CH) begin : g_last
            assign data_d[i*WIDTH +: WIDTH] = in_data_i[(i-1)*WIDTH +: WIDTH];
        end else begin : g_mix
            assign data_d[i*WIDTH +: WIDTH] = WIDTH'(conc_avg(32'(in_data_i[(i-1)*WIDTH +: WIDTH]),
                                                              32'(in_data_i[i*WIDTH +: WIDTH]),
                                                              ROUND_MODE == ROUND_HALF_UP));
        end
    end

    assign load_o  = !valid_q || take_i;
    assign valid_o = valid_q;
    assign data_o  = data_q;

    // Capture upstream stage whenever this slot is free or being drained
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (load_o) begin
            valid_q <= in_valid_i;
            if (in_valid_i) data_q <= data_d;
        end
    end
endmodule

// File: rtl/grad_gen_pipe.sv
// grad_gen_pipe: N-layer diffusion-mixer gradient generator with valid/ready backpressure
module grad_gen_pipe
    import grad_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int NUM_LAYERS = 3,
    parameter int ROUND_MODE = ROUND_HALF_UP
) (
    input logic          clk,
    input logic          rst,
    grad_gen_pipe_if.slave bus
);
    localparam int TOT = ch_base(NUM_LAYERS + 1);
    localparam int OW  = $clog2(NUM_LAYERS + 1);

    logic [TOT*WIDTH-1:0]  ch;
    logic [NUM_LAYERS:0]   v;
    logic [NUM_LAYERS:0]   v_d;
    logic [NUM_LAYERS:1]   load;
    logic [NUM_LAYERS:1]   take;
    logic [OW-1:0]         occ_q;
    logic [OW-1:0]         occ_d;

    assign v[0]               = bus.in_valid;
    assign ch[0 +: 2*WIDTH]   = {bus.soln2_conc, bus.soln1_conc};

    for (genvar k = 1; k <= NUM_LAYERS; k++) begin : g_layer
        if (k == NUM_LAYERS) begin : g_tail
            assign take[k] = bus.out_ready;
        end else begin : g_mid
            assign take[k] = load[k+1];
        end
        grad_layer #(
            .WIDTH(WIDTH),
            .IN_CH(k + 1),
            .ROUND_MODE(ROUND_MODE)
        ) u_layer (
            .clk(clk),
            .rst(rst),
            .in_valid_i(v[k-1]),
            .take_i(take[k]),
            .in_data_i(ch[ch_base(k-1)*WIDTH +: NUM_CH(k-1)*WIDTH]),
            .load_o(load[k]),
            .valid_o(v[k]),
            .data_o(ch[ch_base(k)*WIDTH +: NUM_CH(k)*WIDTH])
        );
    end

    assign bus.in_ready  = load[1];
    assign bus.out_valid = v[NUM_LAYERS];
    assign bus.out_conc  = ch[ch_base(NUM_LAYERS)*WIDTH +: NUM_CH(NUM_LAYERS)*WIDTH];
    assign bus.occupancy = occ_q;

    // Predict next-cycle stage valid bits so occupancy tracks them without lag
    always_comb begin
        v_d    = '0;
        v_d[0] = v[0];
        for (int k = 1; k <= NUM_LAYERS; k++) v_d[k] = load[k] ? v[k-1] : v[k];
        occ_d  = OW'($countones(v_d[NUM_LAYERS:1]));
    end

    // Occupancy register updated in lockstep with the stage valid bits
    always_ff @(posedge clk) begin
        if (rst) occ_q <= '0;
        else     occ_q <= occ_d;
    end
endmodule

// File: tb/tb_grad_gen_pipe.sv
// tb_grad_gen_pipe: directed self-checking bench for grad_gen_pipe
module tb_grad_gen_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    grad_gen_pipe_if #(.WIDTH(8), .NUM_LAYERS(3)) bus ();
    grad_gen_pipe_if #(.WIDTH(8), .NUM_LAYERS(3)) bt ();

    grad_gen_pipe #(.WIDTH(8), .NUM_LAYERS(3), .ROUND_MODE(1)) dut   (.clk(clk), .rst(rst), .bus(bus));
    grad_gen_pipe #(.WIDTH(8), .NUM_LAYERS(3), .ROUND_MODE(0)) dut_t (.clk(clk), .rst(rst), .bus(bt));

    assign bt.in_valid   = bus.in_valid;
    assign bt.soln1_conc = bus.soln1_conc;
    assign bt.soln2_conc = bus.soln2_conc;
    assign bt.out_ready  = bus.out_ready;

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Independent reference: iterate the mixer tree layer by layer on integers
    function automatic logic [39:0] model(input int a, input int b, input int rnd);
        int c [0:4];
        int n [0:4];
        logic [39:0] r;
        c = '{default: 0};
        c[0] = a;
        c[1] = b;
        for (int l = 1; l <= 3; l++) begin
            n = '{default: 0};
            n[0] = c[0];
            n[l+1] = c[l];
            for (int i = 1; i <= l; i++) n[i] = (c[i-1] + c[i] + rnd) / 2;
            c = n;
        end
        for (int i = 0; i < 5; i++) r[i*8 +: 8] = 8'(c[i]);
        return r;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.soln1_conc = 8'd0;
        bus.soln2_conc = 8'd0;
        bus.out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %0b want 0", bus.out_valid); end
        tests++; if (bus.out_conc !== 40'd0) begin fails++; $display("FAIL reset_out_conc got %h want 0", bus.out_conc); end
        tests++; if (bus.occupancy !== 2'd0) begin fails++; $display("FAIL reset_occupancy got %0d want 0", bus.occupancy); end
        tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %0b want 1", bus.in_ready); end
    endtask

    // One beat into an empty pipe; checks latency and both rounding modes
    task automatic run_one(input string name, input logic [7:0] s1, input logic [7:0] s2,
                           input logic [39:0] exp_r, input logic [39:0] exp_t);
        int lat;
        bus.soln1_conc = s1;
        bus.soln2_conc = s2;
        bus.in_valid = 1'b1;
        tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL %s_in_ready got %0b want 1", name, bus.in_ready); end
        tick();
        bus.in_valid = 1'b0;
        bus.soln1_conc = ~s1;
        bus.soln2_conc = ~s2;
        lat = 1;
        while (!bus.out_valid && lat < 8) begin
            tick();
            lat++;
        end
        tests++; if (lat != 3) begin fails++; $display("FAIL %s_latency got %0d want 3", name, lat); end
        tests++; if (bus.out_conc !== exp_r) begin fails++; $display("FAIL %s_round got %h want %h", name, bus.out_conc, exp_r); end
        tests++; if (bt.out_conc !== exp_t) begin fails++; $display("FAIL %s_trunc got %h want %h", name, bt.out_conc, exp_t); end
        tick();
        tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL %s_single_beat got %0b want 0", name, bus.out_valid); end
    endtask

    task automatic test_single();
        run_one("ramp", 8'd0, 8'd255, {8'd255, 8'd224, 8'd128, 8'd32, 8'd0}, {8'd255, 8'd223, 8'd127, 8'd31, 8'd0});
    endtask

    task automatic test_edges();
        run_one("full", 8'd255, 8'd255, {5{8'd255}}, {5{8'd255}});
        run_one("one_zero", 8'd1, 8'd0, {8'd0, 8'd1, 8'd1, 8'd1, 8'd1}, {8'd0, 8'd0, 8'd0, 8'd0, 8'd1});
    endtask

    // Generic stream driver/consumer; stall window holds out_ready low
    task automatic stream(input string name, input int n, input int base, input int st_start, input int st_len);
        int sent = 0;
        int got = 0;
        int cyc = 0;
        int first = -1;
        int last = -1;
        logic [39:0] held = '0;
        bit in_stall = 0;
        bit saw_full = 0;
        bit acc;
        while ((got < n) && cyc < 80) begin
            bus.out_ready = !(cyc >= st_start && cyc < st_start + st_len);
            bus.in_valid = sent < n;
            bus.soln1_conc = 8'(base + sent);
            bus.soln2_conc = 8'(255 - base - sent);
            #1;
            if (st_len == 0) begin
                tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL %s_in_ready cyc %0d got %0b want 1", name, cyc, bus.in_ready); end
            end
            if (bus.occupancy == 2'd3 && !bus.out_ready) begin
                saw_full = 1;
                tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL %s_full_in_ready got %0b want 0", name, bus.in_ready); end
            end
            if (bus.out_valid && !bus.out_ready) begin
                if (in_stall) begin
                    tests++; if (bus.out_conc !== held) begin fails++; $display("FAIL %s_stall_hold got %h want %h", name, bus.out_conc, held); end
                end
                held = bus.out_conc;
                in_stall = 1;
            end else in_stall = 0;
            if (bus.out_valid && bus.out_ready) begin
                tests++;
                if (bus.out_conc !== model(base + got, 255 - base - got, 1)) begin
                    fails++;
                    $display("FAIL %s_data[%0d] got %h want %h", name, got, bus.out_conc, model(base + got, 255 - base - got, 1));
                end
                if (first < 0) first = cyc;
                last = cyc;
                got++;
            end
            acc = bus.in_valid && bus.in_ready;
            tick();
            if (acc) sent++;
            cyc++;
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        tests++; if (got != n) begin fails++; $display("FAIL %s_count got %0d want %0d", name, got, n); end
        if (st_len == 0) begin
            tests++; if (last - first != n - 1) begin fails++; $display("FAIL %s_consecutive got span %0d want %0d", name, last - first, n - 1); end
        end else begin
            tests++; if (!saw_full) begin fails++; $display("FAIL %s_reached_full got 0 want 1", name); end
        end
        for (int i = 0; i < 4; i++) tick();
        tests++; if (bus.out_valid !== 1'b0 || bus.occupancy !== 2'd0) begin
            fails++; $display("FAIL %s_drained got v=%0b occ=%0d want v=0 occ=0", name, bus.out_valid, bus.occupancy);
        end
    endtask

    task automatic test_stream();
        stream("stream", 10, 0, 0, 0);
    endtask

    task automatic test_backpressure();
        stream("bp", 12, 20, 4, 6);
    endtask

    task automatic test_midreset();
        int lat;
        int cnt;
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        bus.soln1_conc = 8'd7;
        bus.soln2_conc = 8'd9;
        tick();
        bus.soln1_conc = 8'd11;
        bus.soln2_conc = 8'd13;
        tick();
        bus.in_valid = 1'b0;
        tests++; if (bus.occupancy !== 2'd2) begin fails++; $display("FAIL midrst_occ_before got %0d want 2", bus.occupancy); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL midrst_out_valid got %0b want 0", bus.out_valid); end
        tests++; if (bus.occupancy !== 2'd0) begin fails++; $display("FAIL midrst_occ got %0d want 0", bus.occupancy); end
        bus.in_valid = 1'b1;
        bus.soln1_conc = 8'd100;
        bus.soln2_conc = 8'd50;
        tick();
        bus.in_valid = 1'b0;
        lat = 1;
        cnt = 0;
        while (lat < 10) begin
            if (bus.out_valid) begin
                cnt++;
                tests++; if (bus.out_conc !== model(100, 50, 1)) begin fails++; $display("FAIL midrst_data got %h want %h", bus.out_conc, model(100, 50, 1)); end
            end
            tick();
            lat++;
        end
        tests++; if (cnt != 1) begin fails++; $display("FAIL midrst_count got %0d want 1", cnt); end
    endtask

    task automatic test_idle_toggle();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.soln1_conc = 8'(i * 37);
            bus.soln2_conc = 8'(i * 91);
            tick();
        end
        tests++; if (bus.occupancy !== 2'd0 || bus.out_valid !== 1'b0) begin
            fails++; $display("FAIL idle_toggle got occ=%0d v=%0b want 0 0", bus.occupancy, bus.out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_edges();
        test_stream();
        test_backpressure();
        test_midreset();
        test_idle_toggle();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/grad_gen_pipe.md
Name: grad_gen_pipe

Overview:
- Parametrised, clocked successor to the fixed 3-layer two-solution gradient generator netlist.
- Computes the concentration at every channel of an N-layer diffusion-mixer tree from two inlet concentration samples.
- One register stage per mixer layer, with valid/ready backpressure.
- Feeds gradient-profile checking and concentration-based control in the simulation flow.

Parameters:
- WIDTH, 8, bits per concentration value (unsigned, full scale = 2^WIDTH-1).
- NUM_LAYERS, 3, mixer layers (>=1). Layer k (1-based) emits k+2 channels.
- ROUND_MODE, 1, 0 = truncate average, 1 = round half up.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  inlet sample valid.
- in_ready  out  1  block can accept an inlet sample this cycle.
- soln1_conc  in  WIDTH  concentration of inlet 1 (channel 0 side).
- soln2_conc  in  WIDTH  concentration of inlet 2 (last-channel side).
- out_valid  out  1  out_conc holds a valid final-layer profile.
- out_ready  in  1  downstream accepts the profile.
- out_conc  out  (NUM_LAYERS+2)*WIDTH  final-layer channels, packed. Channel 0 is at the LSBs.
- occupancy  out  $clog2(NUM_LAYERS+1)  number of valid stages in flight.

Behaviour:
- Reset is synchronous and active-high on clk. All stage valid bits and all data registers go to 0. Outputs after reset: out_valid=0, out_conc=0, occupancy=0, in_ready=1.
- Stage k takes the k+1 channels of stage k-1; stage 0 input is {soln1_conc, soln2_conc}. Stage k produces k+2 channels:
  - out[0] = in[0].
  - out[k+1] = in[k].
  - out[i] = avg(in[i-1], in[i]) for 1<=i<=k.
- avg: sum is computed at WIDTH+1 bits, then shifted right by 1. ROUND_MODE=1 adds 1 before the shift. The result never overflows WIDTH.
- Handshake:
  - adv[NUM_LAYERS] = out_ready.
  - Stage k loads when !v[k] || adv[k+1], where adv[k] = v[k-1] && (stage k loads).
  - in_ready = !v[1] || adv[2], with in_ready = out_ready || !v[1] when NUM_LAYERS=1.
  - in_ready is combinational from out_ready and the valid bits only.
- Timing:
  - Latency is NUM_LAYERS cycles from an in_valid&&in_ready cycle to out_valid, with no stall.
  - Throughput is 1 sample/cycle sustained.
  - Order is preserved. No sample is dropped or duplicated.
- Stall: while out_valid && !out_ready, out_conc stays stable and bubbles in the pipe compress. When all stages are valid, in_ready=0.
- Simultaneous output drain and input accept with a full pipe: both occur in the same cycle, and occupancy is unchanged.
- occupancy = popcount of the stage valid bits, registered alongside them.
- Reset mid-operation: all in-flight samples are discarded. The first post-reset output comes only from samples accepted after rst deasserts.
- in_valid=0 with data toggling: no state change.

Decomposition:
- Package grad_pkg:
  - Rounding mode constants ROUND_TRUNC=0 and ROUND_HALF_UP=1.
  - Function conc_avg(a, b, mode), parameterised by WIDTH via a let/static function.
  - Helper NUM_CH(k) = k+2.
- Sub-module grad_layer: parameters WIDTH, IN_CH, ROUND_MODE. It holds one registered stage with its valid bit and load logic.
- The top generates NUM_LAYERS instances with IN_CH = k+1 and chains the adv/ready signals.

Test Plan:
- Reset, defaults (WIDTH=8, NUM_LAYERS=3, ROUND_MODE=1): soln1=0, soln2=255, one beat, out_ready=1 -> out_valid after 3 cycles, out_conc channels = {0, 32, 128, 224, 255}.
- ROUND_MODE=0, same stimulus -> channels = {0, 31, 127, 223, 255}.
- Streaming: 10 back-to-back samples (soln1=i, soln2=255-i), out_ready=1 -> 10 consecutive out_valid cycles, in order, matching the reference model; in_ready stays 1.
- Backpressure: out_ready=0 for 6 cycles during a stream -> in_ready drops to 0 once occupancy=3. out_conc holds stable. After release, no loss or duplication.
- Edge values: soln1=soln2=255 -> all channels 255, no overflow. soln1=1, soln2=0 with ROUND_MODE=1 -> layer-3 channels {1, 1, 1, 1, 0}.
- Mid-stream reset: rst pulse with occupancy=2 -> next cycle out_valid=0 and occupancy=0. Only post-reset samples ever appear at the output.
